// File: rtl/cache_victim_select.sv
// Round-robin victim selector: prefers the lowest invalid way, otherwise the set's pointer way.
// Optional CACHE_VICTIM_LOCK_EN adds per-way lock masks and a resp_none "no victim" flag.
module cache_victim_select #(
   parameter int WAYS  = 4,
   parameter int SETS  = 16,
   parameter int WAY_W = $clog2(WAYS),
   parameter int SET_W = $clog2(SETS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic [SET_W-1:0] req_set,
   input  logic [WAYS-1:0]  req_valid_mask,
`ifdef CACHE_VICTIM_LOCK_EN
   input  logic [WAYS-1:0]  req_lock_mask,
   output logic             resp_none,
`endif
   output logic             req_ready,
   output logic             resp_valid,
   output logic [WAY_W-1:0] resp_way,
   output logic             resp_invalid,
   input  logic             resp_ready
);

   typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;

   state_t           r_state;
   logic [SET_W-1:0] r_set;
   logic [WAYS-1:0]  r_vmask;
   logic [WAY_W-1:0] r_ptr [SETS];

   logic [WAY_W-1:0] w_ptr;
   logic [WAY_W-1:0] w_inv_way;
   logic [WAY_W-1:0] w_ptr_way;
   logic [WAY_W-1:0] w_idx;
   logic             w_inv_found;
   logic             w_ptr_found;
   logic             w_no_adv;
   logic [WAYS-1:0]  w_lock;
   logic [WAYS-1:0]  w_inv_cand;

`ifdef CACHE_VICTIM_LOCK_EN
   logic [WAYS-1:0]  r_lock;
   assign w_lock   = r_lock;
   assign w_no_adv = resp_invalid | resp_none;
`else
   assign w_lock   = '0;
   assign w_no_adv = resp_invalid;
`endif

   assign req_ready  = (r_state == IDLE);
   assign w_ptr      = r_ptr[r_set];
   assign w_inv_cand = ~r_vmask & ~w_lock;

   // Both searches scan downward so the last hit is the lowest index / nearest from pointer.
   always_comb begin
      w_inv_found = 1'b0;
      w_inv_way   = '0;
      w_ptr_found = 1'b0;
      w_ptr_way   = '0;
      w_idx       = '0;
      for (int i = WAYS-1; i >= 0; i--) begin
         if (w_inv_cand[i]) begin
            w_inv_found = 1'b1;
            w_inv_way   = WAY_W'(i);
         end
         w_idx = w_ptr + WAY_W'(i);
         if (!w_lock[w_idx]) begin
            w_ptr_found = 1'b1;
            w_ptr_way   = w_idx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_set        <= '0;
         r_vmask      <= '0;
         resp_valid   <= 1'b0;
         resp_way     <= '0;
         resp_invalid <= 1'b0;
         for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
`ifdef CACHE_VICTIM_LOCK_EN
         r_lock       <= '0;
         resp_none    <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_set   <= req_set;
                  r_vmask <= req_valid_mask;
`ifdef CACHE_VICTIM_LOCK_EN
                  r_lock  <= req_lock_mask;
`endif
                  r_state <= LOOKUP;
               end
            end
            LOOKUP: begin
               resp_valid <= 1'b1;
               r_state    <= RESP;
`ifdef CACHE_VICTIM_LOCK_EN
               resp_none  <= !w_inv_found && !w_ptr_found;
`endif
               if (w_inv_found) begin
                  resp_way     <= w_inv_way;
                  resp_invalid <= 1'b1;
               end else if (w_ptr_found) begin
                  resp_way     <= w_ptr_way;
                  resp_invalid <= 1'b0;
               end else begin
                  resp_way     <= '0;
                  resp_invalid <= 1'b0;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  r_state    <= IDLE;
                  // Pointer moves past the evicted way; wraps naturally at WAY_W bits.
                  if (!w_no_adv) r_ptr[r_set] <= resp_way + WAY_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
